// File: rtl/vm_pkg.sv
// Shared types and decode helpers for the multi-item vending machine.
// Holds the FSM state encoding, coin codes, coin decode and item pricing.
package vm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INSERT   = 3'd1,
        ST_CHECK    = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_SEL      = 3'd4,
        ST_REFUND   = 3'd5
    } vm_state_t;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_5    = 3'b001;
    localparam logic [2:0] COIN_10   = 3'b010;
    localparam logic [2:0] COIN_20   = 3'b100;

    // Non one-hot codes decode to 0 so they are silently ignored.
    function automatic int unsigned coin_value(input logic [2:0] code);
        case (code)
            COIN_5:  return 5;
            COIN_10: return 10;
            COIN_20: return 20;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned price_of(input int unsigned idx);
        return 10 * (idx + 1);
    endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters with a single decrement strobe and empty flags.
// With VM_RESTOCK_EN defined, restock while idle reloads every counter.
module vm_stock_bank #(
    parameter int NUM_ITEMS  = 4,
    parameter int ITEM_W     = 2,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef VM_RESTOCK_EN
    input  logic                 restock,
    input  logic                 idle,
`endif
    input  logic                 dec,
    input  logic [ITEM_W-1:0]    idx,
    output logic [NUM_ITEMS-1:0] empty
);

    localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(INIT_STOCK);

    generate
        for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_counter
            logic [STOCK_W-1:0] count_reg;
            logic               hit;

            // The zero guard keeps a counter from wrapping even if a caller misbehaves.
            assign hit = dec && (idx == ITEM_W'(gi)) && (count_reg != '0);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    count_reg <= INIT_VAL;
`ifdef VM_RESTOCK_EN
                end else if (restock && idle) begin
                    count_reg <= INIT_VAL;
`endif
                end else if (hit) begin
                    count_reg <= count_reg - STOCK_W'(1);
                end
            end

            assign empty[gi] = (count_reg == '0);
        end
    endgenerate

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending transaction FSM with capped credit, refund and continue-buy.
// Optional restock input is compiled in when VM_RESTOCK_EN is defined.
module vending_machine_multi
    import vm_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int ITEM_W     = $clog2(NUM_ITEMS),
    parameter int MONEY_W    = 8,
    parameter int MAX_MONEY  = 40,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ITEM_W-1:0]    item_in,
    input  logic [2:0]           money,
    input  logic                 done_money,
    input  logic                 cancel,
    input  logic                 continue_buy,
`ifdef VM_RESTOCK_EN
    input  logic                 restock,
`endif
    output logic                 done,
    output logic [NUM_ITEMS-1:0] item_out,
    output logic [MONEY_W-1:0]   change,
    output logic                 end_trans,
    output logic                 out_stock,
    output logic                 coin_reject,
    output logic                 insufficient,
    output logic [2:0]           state
);

    vm_state_t              state_reg, state_next;
    logic [MONEY_W-1:0]     credit_reg, credit_next;
    logic [ITEM_W-1:0]      item_reg, item_next;
    logic                   done_money_q;

    logic                   done_reg, done_next;
    logic [NUM_ITEMS-1:0]   item_out_reg, item_out_next;
    logic [MONEY_W-1:0]     change_reg, change_next;
    logic                   end_trans_reg, end_trans_next;
    logic                   out_stock_reg, out_stock_next;
    logic                   coin_reject_reg, coin_reject_next;
    logic                   insufficient_reg, insufficient_next;

    logic [NUM_ITEMS-1:0]   empty;
    logic                   item_empty;
    logic                   stock_dec;
    logic                   go_refund;
    logic                   done_rise;
    logic [MONEY_W-1:0]     price;
    logic [MONEY_W-1:0]     coin_val;
    logic [MONEY_W:0]       coin_sum;

    vm_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .ITEM_W     (ITEM_W),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef VM_RESTOCK_EN
        .restock (restock),
        .idle    (state_reg == ST_IDLE),
`endif
        .dec     (stock_dec),
        .idx     (item_reg),
        .empty   (empty)
    );

    // Indices beyond NUM_ITEMS (non power-of-two configs) behave as sold out.
    assign item_empty = ({1'b0, item_in} >= (ITEM_W+1)'(NUM_ITEMS)) ? 1'b1 : empty[item_in];

    assign done_rise = done_money && !done_money_q;
    assign price     = MONEY_W'(price_of(32'(item_reg)));
    assign coin_val  = MONEY_W'(coin_value(money));
    assign coin_sum  = {1'b0, credit_reg} + {1'b0, coin_val};

    // Registered outputs are computed on the transition, so they are valid
    // during the first cycle of the state being entered.
    always_comb begin
        state_next        = state_reg;
        credit_next       = credit_reg;
        item_next         = item_reg;
        done_next         = 1'b0;
        item_out_next     = '0;
        change_next       = '0;
        end_trans_next    = 1'b0;
        out_stock_next    = 1'b0;
        coin_reject_next  = 1'b0;
        insufficient_next = 1'b0;
        stock_dec         = 1'b0;
        go_refund         = 1'b0;

        case (state_reg)
            ST_IDLE, ST_SEL: begin
                if (state_reg == ST_SEL && cancel) begin
                    go_refund = 1'b1;
                end else if (start) begin
                    item_next = item_in;
                    if (item_empty) begin
                        out_stock_next = 1'b1;
                        go_refund      = 1'b1;
                    end else begin
                        state_next = ST_INSERT;
                    end
                end
            end

            ST_INSERT: begin
                if (cancel) begin
                    go_refund = 1'b1;
                end else begin
                    if (coin_val != '0) begin
                        if (coin_sum <= (MONEY_W+1)'(MAX_MONEY)) begin
                            credit_next = coin_sum[MONEY_W-1:0];
                        end else begin
                            coin_reject_next = 1'b1;
                        end
                    end
                    if (done_rise) begin
                        state_next = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (credit_reg >= price) begin
                    state_next              = ST_DISPENSE;
                    done_next               = 1'b1;
                    item_out_next[item_reg] = 1'b1;
                    credit_next             = credit_reg - price;
                    stock_dec               = 1'b1;
                end else begin
                    state_next        = ST_INSERT;
                    insufficient_next = 1'b1;
                end
            end

            ST_DISPENSE: begin
                if (continue_buy) begin
                    state_next = ST_SEL;
                end else begin
                    go_refund = 1'b1;
                end
            end

            ST_REFUND: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next  = ST_IDLE;
                credit_next = '0;
            end
        endcase

        if (go_refund) begin
            state_next     = ST_REFUND;
            end_trans_next = 1'b1;
            change_next    = credit_reg;
            credit_next    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            credit_reg       <= '0;
            item_reg         <= '0;
            done_money_q     <= 1'b0;
            done_reg         <= 1'b0;
            item_out_reg     <= '0;
            change_reg       <= '0;
            end_trans_reg    <= 1'b0;
            out_stock_reg    <= 1'b0;
            coin_reject_reg  <= 1'b0;
            insufficient_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            item_reg         <= item_next;
            done_money_q     <= done_money;
            done_reg         <= done_next;
            item_out_reg     <= item_out_next;
            change_reg       <= change_next;
            end_trans_reg    <= end_trans_next;
            out_stock_reg    <= out_stock_next;
            coin_reject_reg  <= coin_reject_next;
            insufficient_reg <= insufficient_next;
        end
    end

    assign done         = done_reg;
    assign item_out     = item_out_reg;
    assign change       = change_reg;
    assign end_trans    = end_trans_reg;
    assign out_stock    = out_stock_reg;
    assign coin_reject  = coin_reject_reg;
    assign insufficient = insufficient_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi: directed scenarios plus
// randomized transactions against a transaction-level credit/stock model.
module tb_vending_machine_multi;

    localparam int CAP  = 40;
    localparam int INIT = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] item_in;
    logic [2:0] money;
    logic       done_money;
    logic       cancel;
    logic       continue_buy;
`ifdef VM_RESTOCK_EN
    logic       restock;
`endif
    logic       done;
    logic [3:0] item_out;
    logic [7:0] change;
    logic       end_trans;
    logic       out_stock;
    logic       coin_reject;
    logic       insufficient;
    logic [2:0] state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Transaction-level model: credit held by the machine, item chosen, stock left.
    int m_credit;
    int m_item;
    int m_stock[4];

    vending_machine_multi dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .item_in      (item_in),
        .money        (money),
        .done_money   (done_money),
        .cancel       (cancel),
        .continue_buy (continue_buy),
`ifdef VM_RESTOCK_EN
        .restock      (restock),
`endif
        .done         (done),
        .item_out     (item_out),
        .change       (change),
        .end_trans    (end_trans),
        .out_stock    (out_stock),
        .coin_reject  (coin_reject),
        .insufficient (insufficient),
        .state        (state)
    );

    always #5 clk = ~clk;

    function automatic int price(input int i);
        return 10 * (i + 1);
    endfunction

    function automatic int coin_val(input logic [2:0] code);
        if (code == 3'b001) return 5;
        if (code == 3'b010) return 10;
        if (code == 3'b100) return 20;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_item   = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = INIT;
    endtask

    task automatic start_item(input int item, input string tag, output bit oos);
        oos = (m_stock[item] == 0);
        m_item = item;
        item_in = 2'(item);
        start = 1'b1;
        step();
        start = 1'b0;
        total_cnt++;
        if (out_stock !== oos) $display("FAIL %s out_stock: got %0b want %0b", tag, out_stock, oos);
        else pass_cnt++;
        total_cnt++;
        if (end_trans !== oos) $display("FAIL %s start_end_trans: got %0b want %0b", tag, end_trans, oos);
        else pass_cnt++;
        if (oos) begin
            total_cnt++;
            if (change !== 8'(m_credit)) $display("FAIL %s oos_change: got %0d want %0d", tag, change, m_credit);
            else pass_cnt++;
            m_credit = 0;
            step();
        end
        $display("txn %s: start item %0d out_stock=%0b", tag, item, out_stock);
    endtask

    task automatic coin(input logic [2:0] code, input string tag);
        int  v;
        bit  rej;
        v   = coin_val(code);
        rej = (v != 0) && (m_credit + v > CAP);
        money = code;
        step();
        money = 3'b000;
        if (!rej) m_credit += v;
        total_cnt++;
        if (coin_reject !== rej) $display("FAIL %s coin_reject: got %0b want %0b", tag, coin_reject, rej);
        else pass_cnt++;
        $display("txn %s: coin %03b reject=%0b model_credit=%0d", tag, code, coin_reject, m_credit);
    endtask

    task automatic cancel_txn(input string tag);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        total_cnt++;
        if (end_trans !== 1'b1) $display("FAIL %s cancel_end_trans: got %0b want 1", tag, end_trans);
        else pass_cnt++;
        total_cnt++;
        if (change !== 8'(m_credit)) $display("FAIL %s cancel_change: got %0d want %0d", tag, change, m_credit);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL %s cancel_done: got %0b want 0", tag, done);
        else pass_cnt++;
        $display("txn %s: cancel change=%0d", tag, change);
        m_credit = 0;
        step();
        total_cnt++;
        if (end_trans !== 1'b0) $display("FAIL %s end_trans_width: got %0b want 0", tag, end_trans);
        else pass_cnt++;
    endtask

    task automatic pay(input bit cont, input string tag, output bit disp);
        logic [3:0] exp_io;
        continue_buy = cont;
        done_money = 1'b1;
        step();
        done_money = 1'b0;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL %s early_done: got %0b want 0", tag, done);
        else pass_cnt++;
        step();
        disp   = (m_credit >= price(m_item));
        exp_io = disp ? 4'(1 << m_item) : 4'd0;
        total_cnt++;
        if (done !== disp) $display("FAIL %s done: got %0b want %0b", tag, done, disp);
        else pass_cnt++;
        total_cnt++;
        if (item_out !== exp_io) $display("FAIL %s item_out: got %04b want %04b", tag, item_out, exp_io);
        else pass_cnt++;
        total_cnt++;
        if (insufficient !== !disp) $display("FAIL %s insufficient: got %0b want %0b", tag, insufficient, !disp);
        else pass_cnt++;
        $display("txn %s: pay item %0d done=%0b insufficient=%0b", tag, m_item, done, insufficient);
        if (disp) begin
            m_credit -= price(m_item);
            m_stock[m_item]--;
            step();
            total_cnt++;
            if (end_trans !== !cont) $display("FAIL %s pay_end_trans: got %0b want %0b", tag, end_trans, !cont);
            else pass_cnt++;
            total_cnt++;
            if (done !== 1'b0) $display("FAIL %s done_width: got %0b want 0", tag, done);
            else pass_cnt++;
            if (!cont) begin
                total_cnt++;
                if (change !== 8'(m_credit)) $display("FAIL %s pay_change: got %0d want %0d", tag, change, m_credit);
                else pass_cnt++;
                $display("txn %s: refund change=%0d", tag, change);
                m_credit = 0;
                step();
            end
        end
        continue_buy = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; item_in = 2'd0; money = 3'b000;
        done_money = 1'b0; cancel = 1'b0; continue_buy = 1'b0;
`ifdef VM_RESTOCK_EN
        restock = 1'b0;
`endif
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;
        step();
        total_cnt++;
        if ({done, item_out, change, end_trans, out_stock, coin_reject, insufficient, state} !== '0)
            $display("FAIL reset_outputs: got done=%0b io=%04b chg=%0d et=%0b os=%0b cr=%0b ins=%0b st=%0d want all 0",
                     done, item_out, change, end_trans, out_stock, coin_reject, insufficient, state);
        else pass_cnt++;
        $display("txn reset: outputs state=%0d", state);
    endtask

    task automatic test_exact_pay();
        bit oos, disp;
        start_item(1, "exact", oos);
        coin(3'b010, "exact");
        coin(3'b010, "exact");
        pay(1'b0, "exact", disp);
    endtask

    task automatic test_overpay();
        bit oos, disp;
        start_item(0, "overpay", oos);
        coin(3'b100, "overpay");
        coin(3'b100, "overpay");
        pay(1'b0, "overpay", disp);
    endtask

    task automatic test_cancel();
        bit oos;
        start_item(3, "cancel", oos);
        coin(3'b001, "cancel");
        coin(3'b010, "cancel");
        cancel_txn("cancel");
    endtask

    task automatic test_cap_insufficient();
        bit oos, disp;
        start_item(3, "cap", oos);
        coin(3'b100, "cap");
        coin(3'b100, "cap");
        coin(3'b001, "cap");
        coin(3'b011, "cap");
        cancel_txn("cap");
        start_item(3, "insuff", oos);
        coin(3'b001, "insuff");
        coin(3'b010, "insuff");
        pay(1'b0, "insuff", disp);
        cancel_txn("insuff");
    endtask

    task automatic test_continue_buy();
        bit oos, disp;
        start_item(0, "contbuy", oos);
        coin(3'b100, "contbuy");
        coin(3'b100, "contbuy");
        pay(1'b1, "contbuy", disp);
        start_item(1, "contbuy", oos);
        pay(1'b0, "contbuy", disp);
    endtask

    task automatic test_out_of_stock();
        bit oos, disp;
        for (int k = 0; k < 3; k++) begin
            start_item(2, "oos_buy", oos);
            coin(3'b100, "oos_buy");
            coin(3'b010, "oos_buy");
            pay(1'b0, "oos_buy", disp);
        end
        start_item(2, "oos_empty", oos);
        total_cnt++;
        if (oos !== 1'b1) $display("FAIL oos_model: got %0b want 1", oos);
        else pass_cnt++;
    endtask

`ifdef VM_RESTOCK_EN
    task automatic test_restock();
        bit oos;
        restock = 1'b1;
        step();
        restock = 1'b0;
        for (int i = 0; i < 4; i++) m_stock[i] = INIT;
        start_item(2, "restock", oos);
        cancel_txn("restock");
    endtask
`endif

    task automatic test_reset_mid();
        bit oos;
        start_item(1, "rstmid", oos);
        coin(3'b100, "rstmid");
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if (end_trans !== 1'b0 || change !== 8'd0) $display("FAIL rstmid_no_refund: got et=%0b chg=%0d want 0", end_trans, change);
        else pass_cnt++;
        step();
        reset_n = 1'b1;
        model_reset();
        step();
        start_item(2, "rstmid_after", oos);
        cancel_txn("rstmid_after");
    endtask

    task automatic test_random();
        bit oos, disp, in_sel;
        logic [2:0] codes [6];
        codes[0] = 3'b001; codes[1] = 3'b010; codes[2] = 3'b100;
        codes[3] = 3'b100; codes[4] = 3'b011; codes[5] = 3'b110;
        in_sel = 1'b0;
        for (int t = 0; t < 40; t++) begin
            start_item(int'($urandom_range(0, 3)), "rand", oos);
            if (oos) begin
                in_sel = 1'b0;
                continue;
            end
            for (int c = 0; c < int'($urandom_range(1, 4)); c++)
                coin(codes[$urandom_range(0, 5)], "rand");
            if ($urandom_range(0, 3) == 0) begin
                cancel_txn("rand");
                in_sel = 1'b0;
            end else begin
                in_sel = 1'($urandom_range(0, 1));
                pay(in_sel, "rand", disp);
                if (!disp) begin
                    cancel_txn("rand");
                    in_sel = 1'b0;
                end
            end
        end
        if (in_sel) cancel_txn("rand_end");
    endtask

    initial begin
        test_reset();
        test_exact_pay();
        test_overpay();
        test_cancel();
        test_cap_insufficient();
        test_continue_buy();
        test_out_of_stock();
`ifdef VM_RESTOCK_EN
        test_restock();
`endif
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
